sqrt_result_packer: RTL and testbench

SQRT_RESULT_PACKER -- requirements
Module: sqrt_result_packer

---
 rtl/sqrt_result_packer.sv | 152 +++++++++++++++
 tb/tb_sqrt_result_packer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sqrt_result_packer.sv
// Packs a square-root datapath result (root, exponent, sticky, class) into IEEE-754 single precision.
// Latency: (32-p)+1 cycles for a normal nonzero root with leading one at bit p, 1 cycle otherwise.
// Backpressure: one operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
module sqrt_result_packer #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_root,
    input  logic [9:0]      in_exp,
    input  logic            in_sticky,
    input  logic [1:0]      in_special,
    input  logic            in_sign,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] CLS_NORMAL = 2'b00;
    localparam logic [1:0] CLS_ZERO   = 2'b01;
    localparam logic [1:0] CLS_INF    = 2'b10;

    localparam logic [31:0] PINF_WORD = 32'h7F80_0000;
    localparam logic [31:0] QNAN_WORD = 32'h7FC0_0000;

    state_t            state;
    logic [SIZE-1:0]   root_reg;
    logic [4:0]        s;
    logic [9:0]        exp_reg;
    logic              sticky_reg;
    logic [1:0]        special_reg;
    logic              sign_reg;

    // Rounding datapath, evaluated from the normalised root while in ROUND
    logic [22:0]       mant;
    logic              guard;
    logic              sticky_all;
    logic              round_up;
    logic [23:0]       mant_inc;
    logic [22:0]       mant_final;
    logic [11:0]       e_raw;
    logic [11:0]       e_final;
    logic [31:0]       packed_word;

    // Round-to-nearest-even on the normalised root and select the final word by class and exponent range
    always_comb begin
        mant        = root_reg[30:8];
        guard       = root_reg[7];
        sticky_all  = (|root_reg[6:0]) | sticky_reg;
        round_up    = guard & (sticky_all | mant[0]);
        mant_inc    = {1'b0, mant} + {23'd0, round_up};
        // The implicit-one position is bit 31 of the root, so bias 127 plus 31 gives 158
        e_raw       = {{2{exp_reg[9]}}, exp_reg} + 12'd158 - {7'd0, s};
        if (mant_inc[23]) begin
            mant_final = 23'd0;
            e_final    = e_raw + 12'd1;
        end else begin
            mant_final = mant_inc[22:0];
            e_final    = e_raw;
        end

        packed_word = 32'd0;
        case (special_reg)
            CLS_NORMAL: begin
                if (root_reg == '0) begin
                    packed_word = 32'd0;
                end else if ($signed(e_final) >= 12'sd255) begin
                    packed_word = PINF_WORD;
                end else if ($signed(e_final) <= 12'sd0) begin
                    // Subnormal results are flushed to zero
                    packed_word = 32'd0;
                end else begin
                    packed_word = {1'b0, e_final[7:0], mant_final};
                end
            end
            CLS_ZERO: packed_word = {sign_reg, 31'd0};
            CLS_INF:  packed_word = PINF_WORD;
            default:  packed_word = QNAN_WORD;
        endcase
    end

    // Control FSM: capture, normalise one bit per cycle, round and register, then hold until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_data    <= 32'd0;
            root_reg    <= '0;
            s           <= 5'd0;
            exp_reg     <= 10'd0;
            sticky_reg  <= 1'b0;
            special_reg <= 2'b00;
            sign_reg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        root_reg    <= in_root;
                        exp_reg     <= in_exp;
                        sticky_reg  <= in_sticky;
                        special_reg <= in_special;
                        sign_reg    <= in_sign;
                        s           <= 5'd0;
                        in_ready    <= 1'b0;
                        if ((in_special == CLS_NORMAL) && (in_root != '0)) begin
                            state <= NORM;
                        end else begin
                            state <= ROUND;
                        end
                    end
                end
                NORM: begin
                    if (root_reg[31]) begin
                        state <= ROUND;
                    end else begin
                        root_reg <= {root_reg[SIZE-2:0], 1'b0};
                        s        <= s + 5'd1;
                    end
                end
                ROUND: begin
                    out_data  <= packed_word;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    // out_data deliberately retains the transferred word until the next ROUND
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_result_packer.sv
module tb_sqrt_result_packer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_root;
    logic [9:0]  in_exp;
    logic        in_sticky;
    logic [1:0]  in_special;
    logic        in_sign;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;

    sqrt_result_packer #(.SIZE(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_root    (in_root),
        .in_exp     (in_exp),
        .in_sticky  (in_sticky),
        .in_special (in_special),
        .in_sign    (in_sign),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    // Present one operand for a single capture edge, then return the number
    // of edges until out_valid is first seen high (100 on timeout)
    task automatic issue(input logic [31:0] root, input int e, input logic stk,
                         input logic [1:0] cls, input logic sgn, output int lat);
        @(negedge clk);
        in_valid   = 1'b1;
        in_root    = root;
        in_exp     = e[9:0];
        in_sticky  = stk;
        in_special = cls;
        in_sign    = sgn;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 100;
        for (int i = 1; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    // Consume the held result and confirm return to IDLE with out_data retained
    task automatic drain(input string tag, input logic [31:0] want);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ovld_after"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_irdy_after"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_data_kept"}, out_data, want);
    endtask

    task automatic run_op(input string tag, input logic [31:0] root, input int e,
                          input logic stk, input logic [1:0] cls, input logic sgn,
                          input logic [31:0] want, input int want_lat);
        int lat;
        issue(root, e, stk, cls, sgn, lat);
        check({tag, "_lat"}, lat, want_lat);
        check({tag, "_data"}, out_data, want);
        drain(tag, want);
    endtask

    initial begin : stim
        int lat;
        int seen;
        logic [31:0] held;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_root    = 32'd0;
        in_exp     = 10'd0;
        in_sticky  = 1'b0;
        in_special = 2'b00;
        in_sign    = 1'b0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ovld", {31'd0, out_valid}, 32'd0);
        check("rst_irdy", {31'd0, in_ready}, 32'd1);
        check("rst_data", out_data, 32'd0);

        // Input offered during reset must not be captured
        @(negedge clk);
        in_valid = 1'b1;
        in_root  = 32'h0000_0001;
        in_exp   = 10'd1;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        check("rst_nocapture", seen, 0);
        check("rst_nocapture_irdy", {31'd0, in_ready}, 32'd1);

        run_op("one_x2",   32'h0000_0001,   1, 1'b0, 2'b00, 1'b0, 32'h4000_0000, 33);
        run_op("carry",    32'hFFFF_FF80, -31, 1'b0, 2'b00, 1'b0, 32'h4000_0000, 2);
        run_op("tie_even", 32'h8000_0080, -31, 1'b0, 2'b00, 1'b0, 32'h3F80_0000, 2);
        run_op("tie_stk",  32'h8000_0080, -31, 1'b1, 2'b00, 1'b0, 32'h3F80_0001, 2);
        run_op("three",    32'h0000_0003,   0, 1'b0, 2'b00, 1'b0, 32'h4040_0000, 32);
        run_op("ffff",     32'h0000_FFFF,   0, 1'b0, 2'b00, 1'b0, 32'h477F_FF00, 18);
        run_op("nan",      32'h1234_5678,   0, 1'b0, 2'b11, 1'b0, 32'h7FC0_0000, 1);
        run_op("negzero",  32'h1234_5678,   0, 1'b0, 2'b01, 1'b1, 32'h8000_0000, 1);
        run_op("poszero",  32'h0000_0000,   0, 1'b0, 2'b01, 1'b0, 32'h0000_0000, 1);
        run_op("inf",      32'h0000_0000,   0, 1'b0, 2'b10, 1'b1, 32'h7F80_0000, 1);
        run_op("rootzero", 32'h0000_0000,  20, 1'b1, 2'b00, 1'b1, 32'h0000_0000, 1);
        run_op("e_max",    32'h8000_0000,  96, 1'b0, 2'b00, 1'b0, 32'h7F00_0000, 2);
        run_op("e_ovf",    32'h8000_0000, 100, 1'b0, 2'b00, 1'b0, 32'h7F80_0000, 2);
        run_op("rnd_ovf",  32'hFFFF_FF80,  96, 1'b0, 2'b00, 1'b0, 32'h7F80_0000, 2);
        run_op("e_min",    32'h8000_0000, -157, 1'b0, 2'b00, 1'b0, 32'h0080_0000, 2);
        run_op("e_zero",   32'h8000_0000, -158, 1'b0, 2'b00, 1'b0, 32'h0000_0000, 2);

        // Hold the result in DONE with new input offered; nothing may change or be accepted
        issue(32'h8000_0080, -31, 1'b1, 2'b00, 1'b0, lat);
        check("hold_lat", lat, 2);
        held = out_data;
        check("hold_data0", held, 32'h3F80_0001);
        @(negedge clk);
        in_valid = 1'b1;
        in_root  = 32'h0000_0001;
        in_exp   = 10'd1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("hold_ovld", {31'd0, out_valid}, 32'd1);
            check("hold_data", out_data, 32'h3F80_0001);
            check("hold_irdy", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        drain("hold", 32'h3F80_0001);
        repeat (3) @(posedge clk);
        #1;
        check("hold_no_extra", {31'd0, out_valid}, 32'd0);

        // Reset mid-normalisation discards the operation
        @(negedge clk);
        in_valid   = 1'b1;
        in_root    = 32'h0000_0001;
        in_exp     = 10'd1;
        in_sticky  = 1'b0;
        in_special = 2'b00;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_irdy", {31'd0, in_ready}, 32'd1);
        check("midrst_data", out_data, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        check("midrst_noout", seen, 0);
        run_op("after_rst", 32'h0000_0001, 1, 1'b0, 2'b00, 1'b0, 32'h4000_0000, 33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
